huff_code_builder: RTL and testbench
====================================

Name: huff_code_builder

Overview:
- Parametrised Huffman code-table builder: N_SYM symbols, codes up to CODE_W bits.
- Sits after the symbol sort/merge controller, which issues one merge step per tree node.
- Each merge step prepends one code bit to every symbol in the two merged groups, and tracks per-symbol code, mask and length.
- Adds a valid/ready merge handshake, automatic completion after N_SYM-1 merges, and sticky overflow/conflict detection.

Parameters:
- N_SYM, 6, number of symbols (2..32)
- CODE_W, 8, maximum code length in bits
- LEN_W, 4, width of per-symbol length field; must hold CODE_W

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; clears table and begins a build
- merge_valid  in  1  merge step present
- merge_ready  out  1  builder accepts merge step
- merge_l  in  N_SYM  bitmask of symbols in the larger-probability group (bit 0)
- merge_s  in  N_SYM  bitmask of symbols in the smaller-probability group (bit 1)
- busy  out  1  high in BUILD
- done  out  1  high in DONE; table stable
- overflow  out  1  sticky; a merge tried to extend a code already CODE_W long
- conflict  out  1  sticky; a symbol was in both masks, or both masks were zero
- merge_cnt  out  LEN_W+2  accepted merges since start
- codes  out  N_SYM*CODE_W  symbol i code at [i*CODE_W +: CODE_W]
- masks  out  N_SYM*CODE_W  symbol i valid-bit mask
- lens  out  N_SYM*LEN_W  symbol i code length

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset: state IDLE. All codes, masks, lens, merge_cnt, overflow, conflict, busy, done and merge_ready are 0.
- FSM states: IDLE, BUILD, DONE.
  - IDLE -> BUILD on start.
  - BUILD -> DONE on the cycle the (N_SYM-1)th merge is accepted; done rises the next cycle.
  - DONE holds until start or reset.
  - start in any state clears codes, masks, lens, merge_cnt and flags, then enters BUILD next cycle.
  - start has priority over a same-cycle merge; that merge is dropped.
- merge_ready = 1 only in BUILD. A merge is accepted on the clk edge where merge_valid && merge_ready. One merge is accepted per cycle; back-to-back merges are allowed.
- Per accepted merge, for each symbol i with exactly one of merge_l[i] / merge_s[i] set, and lens[i] < CODE_W:
  - code bit at position lens[i] <= 0 for l, 1 for s. The code is LSB-aligned and the newest bit is the MSB (root bit).
  - mask bit lens[i] <= 1; lens[i] += 1.
  - These updates are visible the cycle after acceptance.
- Symbols in neither mask are unchanged.
- Symbol in both masks: that symbol is unchanged; conflict is set.
- Both masks all-zero: no table change; conflict is set; merge_cnt still increments.
- Symbol selected with lens[i] == CODE_W: code, mask and len unchanged (saturate); overflow is set. Other symbols in the same step update normally.
- merge_cnt increments on every accepted merge and saturates at N_SYM-1.
- Code bits above lens[i] are always 0; the mask always equals (1<<lens[i])-1.
- Outputs are registered; latency from merge acceptance to updated table is 1 cycle.

Optional Feature:
- Macro: HUFF_MSB_ALIGN_EN.
- Defined: codes and masks are presented MSB-aligned. Symbol i code is shifted left by CODE_W-lens[i], so the root bit sits at bit CODE_W-1 and the mask is the top lens[i] bits. This is combinational from the internal LSB-aligned registers; lens are unchanged.
- Undefined: LSB-aligned presentation as described in Behaviour.

Test Plan:
- Reset during BUILD with 2 merges done -> next cycle all outputs 0, state IDLE, merge_ready 0.
- Default parameters; start, then merges (l,s) = (010000,100000), (001000,000100), (000010,110000), (001100,000001), (110010,001101):
  - codes sym0..5 = 11, 00, 101, 100, 010, 011
  - lens = 2, 2, 3, 3, 3, 3; masks = 03, 03, 07, 07, 07, 07
  - done = 1 after the 5th merge; flags 0.
- Same sequence with HUFF_MSB_ALIGN_EN defined -> sym2 code 0xA0 mask 0xE0; sym0 code 0xC0 mask 0xC0.
- merge_l = merge_s = 000001 -> conflict = 1, sym0 unchanged, merge_cnt = 1.
- CODE_W = 2, sym0 selected in 3 merges -> lens[0] = 2, 3rd merge sets overflow, code unchanged.
- start asserted with merge_valid in same cycle during BUILD -> table cleared, merge dropped, merge_cnt = 0; merge_valid held with merge_ready = 0 in DONE -> no change.

Source files
------------

// File: rtl/huff_code_builder.sv
// Huffman code-table builder: each accepted merge prepends one code bit to every symbol in the two merged groups.
// Optional macro HUFF_MSB_ALIGN_EN presents codes and masks MSB-aligned; the default presentation is LSB-aligned.
module huff_code_builder #(
  parameter int N_SYM  = 6,
  parameter int CODE_W = 8,
  parameter int LEN_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    merge_valid,
  output logic                    merge_ready,
  input  logic [N_SYM-1:0]        merge_l,
  input  logic [N_SYM-1:0]        merge_s,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    conflict,
  output logic [LEN_W+1:0]        merge_cnt,
  output logic [N_SYM*CODE_W-1:0] codes,
  output logic [N_SYM*CODE_W-1:0] masks,
  output logic [N_SYM*LEN_W-1:0]  lens
);

  typedef enum logic [1:0] {IDLE, BUILD, DONE} state_t;

  localparam logic [LEN_W+1:0] LAST_CNT    = (LEN_W+2)'(N_SYM - 1);
  localparam logic [LEN_W+1:0] LAST_CNT_M1 = (LEN_W+2)'(N_SYM - 2);
  localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(CODE_W);

  state_t state, state_nxt;

  logic [CODE_W-1:0] code_q  [N_SYM];
  logic [CODE_W-1:0] mask_q  [N_SYM];
  logic [LEN_W-1:0]  len_q   [N_SYM];
  logic [CODE_W-1:0] bit_sel [N_SYM];
  logic [N_SYM-1:0]  at_max;
  logic [N_SYM-1:0]  sel_one;
  logic              accept;
  logic              step_conflict;
  logic              step_overflow;

  // start wins over a same-cycle merge, so a merge is only taken when start is low
  assign accept = merge_valid && merge_ready && !start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    merge_ready = (state == BUILD);
    busy        = (state == BUILD);
    done        = (state == DONE);
    if (start) begin
      state_nxt = BUILD;
    end else if (state == BUILD && accept && merge_cnt == LAST_CNT_M1) begin
      state_nxt = DONE;
    end
  end

  always_comb begin
    sel_one = merge_l ^ merge_s;
    for (int i = 0; i < N_SYM; i++) begin
      bit_sel[i] = CODE_W'(1) << len_q[i];
      at_max[i]  = (len_q[i] == MAX_LEN);
    end
    step_conflict = (|(merge_l & merge_s)) || ((merge_l | merge_s) == '0);
    step_overflow = |(sel_one & at_max);
  end

  // Symbols selected by exactly one group gain a bit at position len; full-length codes saturate
  always_ff @(posedge clk) begin
    if (reset || start) begin
      merge_cnt <= '0;
      overflow  <= 1'b0;
      conflict  <= 1'b0;
      for (int i = 0; i < N_SYM; i++) begin
        code_q[i] <= '0;
        mask_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else if (accept) begin
      if (merge_cnt != LAST_CNT) merge_cnt <= merge_cnt + 1'b1;
      if (step_conflict) conflict <= 1'b1;
      if (step_overflow) overflow <= 1'b1;
      for (int i = 0; i < N_SYM; i++) begin
        if (sel_one[i] && !at_max[i]) begin
          code_q[i] <= code_q[i] | (merge_s[i] ? bit_sel[i] : '0);
          mask_q[i] <= mask_q[i] | bit_sel[i];
          len_q[i]  <= len_q[i] + LEN_W'(1);
        end
      end
    end
  end

`ifdef HUFF_MSB_ALIGN_EN
  logic [LEN_W:0] sh_amt [N_SYM];

  // Shift so the root bit lands at CODE_W-1
  always_comb begin
    codes = '0;
    masks = '0;
    lens  = '0;
    for (int i = 0; i < N_SYM; i++) begin
      sh_amt[i] = (LEN_W+1)'(CODE_W) - {1'b0, len_q[i]};
      codes[i*CODE_W +: CODE_W] = code_q[i] << sh_amt[i];
      masks[i*CODE_W +: CODE_W] = mask_q[i] << sh_amt[i];
      lens[i*LEN_W +: LEN_W]    = len_q[i];
    end
  end
`else
  always_comb begin
    codes = '0;
    masks = '0;
    lens  = '0;
    for (int i = 0; i < N_SYM; i++) begin
      codes[i*CODE_W +: CODE_W] = code_q[i];
      masks[i*CODE_W +: CODE_W] = mask_q[i];
      lens[i*LEN_W +: LEN_W]    = len_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_huff_code_builder.sv
// Self-checking bench for huff_code_builder: directed cases with literal expectations plus randomized merges
// checked every cycle against a per-symbol arithmetic model of the code table.
module tb_huff_code_builder;

  localparam int N = 6;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          reset, start, merge_valid;
  logic [N-1:0]  merge_l, merge_s;
  logic          merge_ready, busy, done, overflow, conflict;
  logic [5:0]    merge_cnt;
  logic [N*W-1:0] codes, masks;
  logic [N*4-1:0] lens;

  // second instance with short codes so saturation can be reached
  logic          start2, merge_valid2;
  logic [N-1:0]  merge_l2, merge_s2;
  logic          merge_ready2, busy2, done2, overflow2, conflict2;
  logic [4:0]    merge_cnt2;
  logic [N*2-1:0] codes2, masks2;
  logic [N*3-1:0] lens2;

  int n_checks = 0;
  int n_pass   = 0;
  bit check_en = 0;

  int m_code [N];
  int m_len  [N];
  int m_cnt;
  bit m_ovf, m_cfl, m_building, m_finished;

  always #5 clk = ~clk;

  huff_code_builder #(.N_SYM(N), .CODE_W(W), .LEN_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .merge_valid(merge_valid), .merge_ready(merge_ready),
    .merge_l(merge_l), .merge_s(merge_s), .busy(busy), .done(done), .overflow(overflow),
    .conflict(conflict), .merge_cnt(merge_cnt), .codes(codes), .masks(masks), .lens(lens)
  );

  huff_code_builder #(.N_SYM(N), .CODE_W(2), .LEN_W(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .merge_valid(merge_valid2), .merge_ready(merge_ready2),
    .merge_l(merge_l2), .merge_s(merge_s2), .busy(busy2), .done(done2), .overflow(overflow2),
    .conflict(conflict2), .merge_cnt(merge_cnt2), .codes(codes2), .masks(masks2), .lens(lens2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic st, input logic v,
                               input logic [N-1:0] l, input logic [N-1:0] s);
    reset = rst; start = st; merge_valid = v; merge_l = l; merge_s = s;
    tick();
    reset = 1'b0; start = 1'b0; merge_valid = 1'b0;
  endtask

  task automatic applyStimulus2(input logic st, input logic v, input logic [N-1:0] l, input logic [N-1:0] s);
    start2 = st; merge_valid2 = v; merge_l2 = l; merge_s2 = s;
    tick();
    start2 = 1'b0; merge_valid2 = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_code[i] = 0;
      m_len[i]  = 0;
    end
    m_cnt = 0; m_ovf = 0; m_cfl = 0;
  endtask

  // Reference: a code is an integer gaining value (bit << length) per merge; mask = 2^len - 1
  always @(posedge clk) begin
    if (reset) begin
      model_clear();
      m_building = 0; m_finished = 0;
    end else if (start) begin
      model_clear();
      m_building = 1; m_finished = 0;
    end else if (m_building && merge_valid) begin
      if (merge_l == 0 && merge_s == 0) m_cfl = 1;
      for (int i = 0; i < N; i++) begin
        if (merge_l[i] && merge_s[i]) m_cfl = 1;
        else if (merge_l[i] || merge_s[i]) begin
          if (m_len[i] == W) m_ovf = 1;
          else begin
            m_code[i] = m_code[i] + (merge_s[i] ? (1 << m_len[i]) : 0);
            m_len[i]  = m_len[i] + 1;
          end
        end
      end
      if (m_cnt < N - 1) m_cnt = m_cnt + 1;
      if (m_cnt == N - 1) begin
        m_building = 0; m_finished = 1;
      end
    end
  end

  function automatic int present(input int v, input int len);
`ifdef HUFF_MSB_ALIGN_EN
    return (v << (W - len)) & ((1 << W) - 1);
`else
    return v;
`endif
  endfunction

  function automatic logic [N*W-1:0] exp_codes();
    logic [N*W-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(present(m_code[i], m_len[i]));
    return r;
  endfunction

  function automatic logic [N*W-1:0] exp_masks();
    logic [N*W-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(present((1 << m_len[i]) - 1, m_len[i]));
    return r;
  endfunction

  function automatic logic [N*4-1:0] exp_lens();
    logic [N*4-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(m_len[i]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("codes", 64'(codes), 64'(exp_codes()));
      checkOutput("masks", 64'(masks), 64'(exp_masks()));
      checkOutput("lens", 64'(lens), 64'(exp_lens()));
      checkOutput("merge_cnt", 64'(merge_cnt), 64'(m_cnt));
      checkOutput("flags busy/done/ready/ovf/cfl", 64'({busy, done, merge_ready, overflow, conflict}),
                  64'({m_building, m_finished, m_building, m_ovf, m_cfl}));
    end
  end

  logic [5:0] ex_l [5] = '{6'b010000, 6'b001000, 6'b000010, 6'b001100, 6'b110010};
  logic [5:0] ex_s [5] = '{6'b100000, 6'b000100, 6'b110000, 6'b000001, 6'b001101};

  initial begin
    logic [N-1:0] rl, rs;
    int r, k;
    reset = 1'b1; start = 1'b0; merge_valid = 1'b0; merge_l = '0; merge_s = '0;
    start2 = 1'b0; merge_valid2 = 1'b0; merge_l2 = '0; merge_s2 = '0;
    tick();
    tick();
    reset = 1'b0;
    check_en = 1;
    checkOutput("reset codes", 64'(codes), 64'd0);
    checkOutput("reset flags", 64'({busy, done, merge_ready, overflow, conflict, merge_cnt}), 64'd0);

    $display("[TB] reset during BUILD");
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, ex_l[0], ex_s[0]);
    applyStimulus(0, 0, 1, ex_l[1], ex_s[1]);
    checkOutput("build cnt before reset", 64'(merge_cnt), 64'd2);
    applyStimulus(1, 0, 0, '0, '0);
    checkOutput("reset mid-build lens", 64'(lens), 64'd0);
    checkOutput("reset mid-build flags", 64'({busy, done, merge_ready, merge_cnt}), 64'd0);

    $display("[TB] worked example");
    applyStimulus(0, 1, 0, '0, '0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, ex_l[i], ex_s[i]);
`ifdef HUFF_MSB_ALIGN_EN
    checkOutput("example codes", 64'(codes), 64'h6040_80A0_00C0);
    checkOutput("example masks", 64'(masks), 64'hE0E0_E0E0_C0C0);
`else
    checkOutput("example codes", 64'(codes), 64'h0302_0405_0003);
    checkOutput("example masks", 64'(masks), 64'h0707_0707_0303);
`endif
    checkOutput("example lens", 64'(lens), 64'h33_3322);
    checkOutput("example done/flags", 64'({done, busy, overflow, conflict}), 64'b1000);
    checkOutput("example cnt", 64'(merge_cnt), 64'd5);
    applyStimulus(0, 0, 1, 6'b111111, 6'b000000);
    applyStimulus(0, 0, 1, 6'b111111, 6'b000000);
    checkOutput("DONE holds lens", 64'(lens), 64'h33_3322);
    checkOutput("DONE holds cnt/ready", 64'({merge_ready, merge_cnt}), 64'd5);

    $display("[TB] conflict");
    applyStimulus(0, 1, 0, '0, '0);
    applyStimulus(0, 0, 1, 6'b000001, 6'b000001);
    checkOutput("conflict flag", 64'({conflict, overflow}), 64'b10);
    checkOutput("conflict cnt", 64'(merge_cnt), 64'd1);
    checkOutput("conflict sym0 len", 64'(lens[3:0]), 64'd0);

    $display("[TB] start with same-cycle merge");
    applyStimulus(0, 0, 1, 6'b000001, 6'b000010);
    applyStimulus(0, 1, 1, 6'b000100, 6'b001000);
    checkOutput("start drops merge cnt", 64'(merge_cnt), 64'd0);
    checkOutput("start drops merge lens", 64'(lens), 64'd0);
    checkOutput("start clears conflict", 64'({busy, conflict}), 64'b10);

    $display("[TB] randomized merges");
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      rl = '0; rs = '0;
      if ($urandom_range(0, 19) != 0) begin
        for (int i = 0; i < N; i++) begin
          k = $urandom_range(0, 9);
          if (k < 4) rl[i] = 1'b1;
          else if (k < 8) rs[i] = 1'b1;
          else if (k == 9) begin rl[i] = 1'b1; rs[i] = 1'b1; end
        end
      end
      applyStimulus(r < 2, (r >= 2 && r < 9), $urandom_range(0, 2) != 0, rl, rs);
    end

    $display("[TB] overflow with CODE_W=2");
    applyStimulus2(1, 0, '0, '0);
    applyStimulus2(0, 1, 6'b000001, 6'b000010);
    applyStimulus2(0, 1, 6'b000010, 6'b000001);
    checkOutput("short sym0 len", 64'(lens2[2:0]), 64'd2);
    checkOutput("short no overflow yet", 64'(overflow2), 64'd0);
    applyStimulus2(0, 1, 6'b000001, 6'b000010);
    checkOutput("short overflow", 64'(overflow2), 64'd1);
    checkOutput("short sym0 len saturated", 64'(lens2[2:0]), 64'd2);
    checkOutput("short sym0 code kept", 64'({codes2[1:0], masks2[1:0]}), 64'b1011);
    checkOutput("short cnt", 64'(merge_cnt2), 64'd3);

    check_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
